// File: rtl/com_bus_arb_pkg.sv
// Shared types and helpers for the round-robin common-bus arbiter.
// Optional hold-timeout feature: define COM_BUS_ARB_TIMEOUT_EN.
package com_bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROC      = 3'd1,
    PROC_NEST = 3'd2,
    NEST_ONLY = 3'd3,
    RELEASE   = 3'd4
  } arb_state_e;

  localparam int DEF_NUM_CORES = 4;

  // Width of an index into n lines; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_if.sv
// Request/grant bundle between the bus requesters and the common-bus arbiter.
// master = requester side, slave = arbiter side.
interface com_bus_arbiter_rr_if
  import com_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2 * DEF_NUM_CORES,
  parameter int IDW     = idx_w(NUM_REQ)
) ();

  logic [NUM_REQ-1:0] com_bus_req_proc;
  logic [NUM_REQ-1:0] com_bus_req_snoop;
  logic               mem_snoop_req;
  logic [NUM_REQ-1:0] com_bus_gnt_proc;
  logic [NUM_REQ-1:0] com_bus_gnt_snoop;
  logic               mem_snoop_gnt;
  logic               bus_busy;
  logic [IDW-1:0]     gnt_id;
  logic               proto_err;

  modport master (
    output com_bus_req_proc, com_bus_req_snoop, mem_snoop_req,
    input  com_bus_gnt_proc, com_bus_gnt_snoop, mem_snoop_gnt,
    input  bus_busy, gnt_id, proto_err
  );

  modport slave (
    input  com_bus_req_proc, com_bus_req_snoop, mem_snoop_req,
    output com_bus_gnt_proc, com_bus_gnt_snoop, mem_snoop_gnt,
    output bus_busy, gnt_id, proto_err
  );

endinterface

// File: rtl/com_bus_arbiter_rr_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module rr_pick
  import com_bus_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand [N];

  // cand[k] is the index examined k-th, i.e. (start + k) mod N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum       = {1'b0, start_i} + (IW+1)'(gi);
    assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end

  logic          hit;
  logic [IW-1:0] pick;

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && req_i[cand[i]]) begin
        hit  = 1'b1;
        pick = cand[i];
      end
    end
  end

  assign found_o  = hit;
  assign idx_o    = pick;
  assign onehot_o = hit ? (N'(1) << pick) : '0;

endmodule

// File: rtl/com_bus_arbiter_rr.sv
// Round-robin common-bus arbiter: one processor-side grant plus one nested snoop/memory grant.
// Optional hold timeout enabled by defining COM_BUS_ARB_TIMEOUT_EN.
module com_bus_arbiter_rr
  import com_bus_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int NUM_REQ   = 2 * NUM_CORES,
  parameter int IDW       = idx_w(NUM_REQ)
`ifdef COM_BUS_ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 256
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  com_bus_arbiter_rr_if.slave bus
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     proc_ptr_q, proc_ptr_d;
  logic [IDW-1:0]     snoop_ptr_q, snoop_ptr_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] gnt_proc_q, gnt_proc_d;
  logic [NUM_REQ-1:0] gnt_snoop_q, gnt_snoop_d;
  logic               mem_gnt_q, mem_gnt_d;
  logic               busy_q, busy_d;
  logic               perr_q, perr_d;

  logic [NUM_REQ-1:0] proc_cand, snoop_cand;
  logic [NUM_REQ-1:0] p_onehot, s_onehot;
  logic [IDW-1:0]     p_idx, s_idx;
  logic               p_found, s_found;
  logic               proc_held, nest_held, release_now;
  logic               timeout;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

`ifdef COM_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] block_q, block_d;

  // A timed-out requester stays masked until it lowers its request.
  assign proc_cand = bus.com_bus_req_proc & ~block_q;
  assign timeout   = (state_q inside {PROC, PROC_NEST, NEST_ONLY}) &&
                     (cnt_q == CW'(MAX_HOLD - 1));

  always_comb begin
    cnt_d   = (state_q inside {IDLE, RELEASE}) ? '0 : cnt_q + 1'b1;
    block_d = (block_q & bus.com_bus_req_proc) | (timeout ? gnt_proc_q : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end
`else
  assign proc_cand = bus.com_bus_req_proc;
  assign timeout   = 1'b0;
`endif

  // The grantee may never be its own snooper.
  assign snoop_cand = bus.com_bus_req_snoop & ~gnt_proc_q;
  assign proc_held  = |(bus.com_bus_req_proc & gnt_proc_q);
  assign nest_held  = |(bus.com_bus_req_snoop & gnt_snoop_q) |
                      (bus.mem_snoop_req & mem_gnt_q);

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_proc_pick (
    .req_i    (proc_cand),
    .start_i  (proc_ptr_q),
    .found_o  (p_found),
    .onehot_o (p_onehot),
    .idx_o    (p_idx)
  );

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_snoop_pick (
    .req_i    (snoop_cand),
    .start_i  (snoop_ptr_q),
    .found_o  (s_found),
    .onehot_o (s_onehot),
    .idx_o    (s_idx)
  );

  always_comb begin
    state_d     = state_q;
    proc_ptr_d  = proc_ptr_q;
    snoop_ptr_d = snoop_ptr_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    mem_gnt_d   = mem_gnt_q;
    gnt_id_d    = gnt_id_q;
    perr_d      = 1'b0;
    release_now = 1'b0;

    if ((state_q == PROC || state_q == PROC_NEST) &&
        |(bus.com_bus_req_snoop & gnt_proc_q))
      perr_d = 1'b1;

    unique case (state_q)
      // RELEASE is the dead cycle; its arbitration decision lands on the
      // following edge so a new grant appears two cycles after the drop.
      IDLE, RELEASE: begin
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        mem_gnt_d   = 1'b0;
        gnt_id_d    = '0;
        state_d     = IDLE;
        if (|bus.com_bus_req_snoop)                  perr_d = 1'b1;
        if (state_q == IDLE && bus.mem_snoop_req)    perr_d = 1'b1;
        if (p_found) begin
          gnt_proc_d = p_onehot;
          gnt_id_d   = p_idx;
          proc_ptr_d = ptr_after(p_idx);
          state_d    = PROC;
        end
      end
      PROC: begin
        if (!proc_held) begin
          release_now = 1'b1;
        end else if (s_found) begin
          gnt_snoop_d = s_onehot;
          snoop_ptr_d = ptr_after(s_idx);
          state_d     = PROC_NEST;
        end else if (bus.mem_snoop_req) begin
          mem_gnt_d   = 1'b1;
          state_d     = PROC_NEST;
        end
      end
      PROC_NEST: begin
        if (!proc_held && !nest_held) begin
          release_now = 1'b1;
        end else if (!nest_held) begin
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          state_d     = PROC;
        end else if (!proc_held) begin
          gnt_proc_d  = '0;
          gnt_id_d    = '0;
          state_d     = NEST_ONLY;
        end
      end
      NEST_ONLY: begin
        if (!nest_held) release_now = 1'b1;
      end
      default: release_now = 1'b1;
    endcase

    // proc_ptr already sits past the grantee since grant time.
    if (timeout) begin
      release_now = 1'b1;
      perr_d      = 1'b1;
      snoop_ptr_d = snoop_ptr_q;
    end

    if (release_now) begin
      state_d     = RELEASE;
      gnt_proc_d  = '0;
      gnt_snoop_d = '0;
      mem_gnt_d   = 1'b0;
      gnt_id_d    = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      proc_ptr_q  <= '0;
      snoop_ptr_q <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      mem_gnt_q   <= 1'b0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      proc_ptr_q  <= proc_ptr_d;
      snoop_ptr_q <= snoop_ptr_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      mem_gnt_q   <= mem_gnt_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.com_bus_gnt_proc  = gnt_proc_q;
  assign bus.com_bus_gnt_snoop = gnt_snoop_q;
  assign bus.mem_snoop_gnt     = mem_gnt_q;
  assign bus.bus_busy          = busy_q;
  assign bus.gnt_id            = gnt_id_q;
  assign bus.proto_err         = perr_q;

endmodule
